// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive and transmit paths.
//   ASCII_*     : character codes used for the decimal line framing
//   rx_state_t  : receiver bit-level state machine encoding
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART byte receiver.
//   clk, rst_n  : system clock, async active-low reset
//   rx          : raw serial line (idle high, asynchronous)
//   rxbyte      : last received byte, valid while rxvalid is high
//   rxvalid     : one-cycle strobe, byte received with a good stop bit
//   frame_err   : one-cycle strobe, stop bit sampled low
//   busy        : high from start-bit detection to the end of the stop sample
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    // The synchronizer resets low so a line that is already low when reset
    // releases never looks like a 1->0 transition; a start needs a real edge.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           rxvalid_q, rxvalid_d;
    logic           ferr_q, ferr_d;
    logic           fall;

    assign fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rxvalid_d = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Count starts at 1 so the start sample lands HALF clk after
                // the synchronized edge.
                if (fall) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = IDLE;        // false start, glitch only
                    end else begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    state_d = IDLE;
                    if (rx_sync_q) rxvalid_d = 1'b1;
                    else           ferr_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            rxvalid_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rxvalid_q <= rxvalid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rxbyte    = shift_q;
    assign rxvalid   = rxvalid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: rtl/uart_dec_rx.sv
// uart_dec_rx: receives ASCII decimal lines ("00123\r\n") over an 8N1 UART
// and converts them to a 16-bit binary value.
//   clk, rst_n : system clock, async active-low reset
//   rx         : raw UART line
//   value      : last successfully decoded number, held until next valid
//   valid      : one-cycle pulse when value updates
//   err        : one-cycle pulse when a non-empty line is rejected
//   busy       : receiver is inside a frame
module uart_dec_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0] rxbyte;
    logic       rxvalid, frame_err;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rxbyte    (rxbyte),
        .rxvalid   (rxvalid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    logic [16:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        eflag_q, eflag_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [7:0]  digit;
    logic [20:0] prod;
    logic        is_digit, is_term;

    assign digit    = rxbyte - ASCII_0;
    // 21 bits covers the worst case 131071*10+9 before saturation.
    assign prod     = {4'b0, acc_q} * 21'd10 + {13'b0, digit};
    assign is_digit = (rxbyte >= ASCII_0) && (rxbyte <= ASCII_9);
    assign is_term  = (rxbyte == ASCII_CR) || (rxbyte == ASCII_LF);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        eflag_d = eflag_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (frame_err) begin
            eflag_d = 1'b1;
        end else if (rxvalid) begin
            if (is_digit) begin
                acc_d = (prod > 21'h1FFFF) ? 17'h1FFFF : prod[16:0];
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                if ((int'(cnt_d) > MAX_DIGITS) || (acc_d > 17'h0FFFF))
                    eflag_d = 1'b1;
            end else if (is_term) begin
                // Empty lines (second half of CR LF) produce nothing.
                if (eflag_q) begin
                    err_d = 1'b1;
                end else if (cnt_q != 8'd0) begin
                    value_d = acc_q[15:0];
                    valid_d = 1'b1;
                end
                acc_d   = '0;
                cnt_d   = '0;
                eflag_d = 1'b0;
            end else begin
                eflag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            eflag_q <= 1'b0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            eflag_q <= eflag_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_uart_dec_rx.sv
module tb_uart_dec_rx;

    // 9600 baud with a reduced clock so a bit is 16 clk and the run stays short.
    localparam int CLK_HZ = 153_600;
    localparam int BAUD   = 9600;
    localparam int CPB    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b0;
    logic [15:0] value;
    logic        valid, err, busy;

    always #5 clk = ~clk;

    uart_dec_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .value (value),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_both = 0, n_busy = 0;
    int valid_cyc = 0, start_cyc = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (err) n_err++;
        if (valid && err) n_both++;
        if (busy && !busy_prev) n_busy++;
        busy_prev = busy;
    end

    typedef struct {
        logic [63:0] txt;     // right-justified characters, first char highest
        int          len;
        int          n_valid;
        int          n_err;
        int          val;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_valid = 0;
        n_err   = 0;
        n_busy  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        rx = stop_bit;
        wait_clk(CPB);
        rx = 1'b1;
    endtask

    task automatic send_line(input logic [63:0] txt, input int len);
        for (int i = 0; i < len; i++)
            send_byte(txt[8*(len-1-i) +: 8], 1'b1);
        wait_clk(2 * CPB);
    endtask

    initial begin
        logic [7:0] last_ch;
        logic [7:0] nine;
        int lat;

        vecs[0] = '{"00123\015\012", 7, 1, 0, 123};
        vecs[1] = '{"65535\015",     6, 1, 0, 65535};
        vecs[2] = '{"65536\015",     6, 0, 1, 65535};
        vecs[3] = '{"12a4\015",      5, 0, 1, 65535};
        vecs[4] = '{"123456\015",    7, 0, 1, 65535};
        vecs[5] = '{"00000\015",     6, 1, 0, 0};
        vecs[6] = '{"99999\012",     6, 0, 1, 0};

        // Reset with the line held low.
        rx = 1'b0;
        rst_n = 1'b0;
        wait_clk(5);
        check("reset value", int'(value), 0);
        check("reset valid", int'(valid), 0);
        check("reset err",   int'(err),   0);
        check("reset busy",  int'(busy),  0);
        rst_n = 1'b1;
        wait_clk(3 * CPB);
        check("low line at reset is no start", n_busy, 0);
        rx = 1'b1;
        wait_clk(2 * CPB);
        check("idle rise is no start", n_busy, 0);

        for (int v = 0; v < 7; v++) begin
            clr();
            send_line(vecs[v].txt, vecs[v].len);
            check($sformatf("vec%0d valid count", v), n_valid, vecs[v].n_valid);
            check($sformatf("vec%0d err count", v),   n_err,   vecs[v].n_err);
            check($sformatf("vec%0d value", v),       int'(value), vecs[v].val);
            check($sformatf("vec%0d busy frames", v), n_busy,  vecs[v].len);
            last_ch = vecs[v].txt[7:0];
            if (vecs[v].n_valid == 1 && last_ch == 8'h0D) begin
                lat = valid_cyc - start_cyc;
                if (lat < 150 || lat > 160)
                    $display("latency %0d clk from terminator start edge", lat);
                check($sformatf("vec%0d valid latency", v),
                      int'(lat >= 150 && lat <= 160), 1);
            end
        end

        // Short low glitch: a false start, then an empty CR LF line.
        clr();
        rx = 1'b0;
        wait_clk(5);
        rx = 1'b1;
        wait_clk(2 * CPB);
        send_line("\015\012", 2);
        check("glitch busy pulses", n_busy, 3);
        check("glitch valid", n_valid, 0);
        check("glitch err", n_err, 0);

        // Framing error poisons its line; the next line is fine.
        clr();
        send_byte(8'h35, 1'b0);
        wait_clk(CPB);
        send_line("\015", 1);
        check("frame err line err", n_err, 1);
        check("frame err line valid", n_valid, 0);
        clr();
        send_line("7\015", 2);
        check("after frame err valid", n_valid, 1);
        check("after frame err value", int'(value), 7);
        check("after frame err err", n_err, 0);

        // Reset during bit 4 of '9' after "4".
        clr();
        send_byte(8'h34, 1'b1);
        nine = 8'h39;
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = nine[i];
            wait_clk(CPB);
        end
        rx = nine[4];
        wait_clk(CPB / 2);
        rst_n = 1'b0;
        wait_clk(1);
        check("midreset value", int'(value), 0);
        check("midreset valid", int'(valid), 0);
        check("midreset err",   int'(err),   0);
        check("midreset busy",  int'(busy),  0);
        rx = 1'b1;
        wait_clk(CPB);
        rst_n = 1'b1;
        wait_clk(2 * CPB);
        clr();
        send_line("8\015", 2);
        check("post reset valid", n_valid, 1);
        check("post reset value", int'(value), 8);
        check("post reset err", n_err, 0);

        check("valid and err same cycle", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
